// File: rtl/costas_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : costas_loop_filter
// Purpose  : Feedback end of a BPSK Costas loop. Integrates-and-dumps the
//            baseband I/Q mixer products over one symbol of ACC_LEN samples,
//            forms the phase error sign(I)*Q and filters it through a
//            saturating proportional-integral loop filter. One signed
//            phase-increment correction word is emitted per symbol for the
//            NCO. There is no backpressure.
//
// Ports    : clk             - system clock, all logic on the rising edge
//            rst             - synchronous active-high reset
//            i_tdata         - signed in-phase mixer output (WIDTH)
//            q_tdata         - signed quadrature mixer output (WIDTH)
//            iq_tvalid       - sample strobe, one sample accepted per high cycle
//            feedback_tdata  - signed phase-increment correction (WIDTH)
//            feedback_tvalid - one-cycle pulse per symbol
//            lock            - lock indicator (constant 0 unless enabled)
//
// Options  : COSTAS_LOCK_DETECT_EN - compiles the lock detector. Without it
//            no detector logic exists and lock is tied low.
//
// Pipeline : stage 1 accumulate/dump, stage 2 phase error, stage 3 PI filter.
//            Last sample accepted at cycle N -> feedback_tvalid at cycle N+3.
//
// Revision : 1.0 - initial release
// ============================================================================
module costas_loop_filter #(
    parameter int WIDTH    = 16,
    parameter int ACC_LOG2 = 4,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] i_tdata,
    input  logic signed [WIDTH-1:0] q_tdata,
    input  logic                    iq_tvalid,
    output logic signed [WIDTH-1:0] feedback_tdata,
    output logic                    feedback_tvalid,
    output logic                    lock
);

    // Accumulator width: ACC_LEN samples of WIDTH bits can never overflow.
    localparam int c_AW = WIDTH + ACC_LOG2;

    localparam logic [ACC_LOG2-1:0]    c_CNT_LAST = {ACC_LOG2{1'b1}};
    localparam logic signed [WIDTH-1:0] c_MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp a WIDTH+1 bit sum back into WIDTH bits. Overflow is visible as a
    // disagreement between the two top bits of the wider value.
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH:0] x);
        if (x[WIDTH] != x[WIDTH-1]) begin
            return x[WIDTH] ? c_MIN_W : c_MAX_W;
        end
        return x[WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Stage 1: integrate and dump
    // ------------------------------------------------------------------------
    logic [ACC_LOG2-1:0]    cnt_q,    cnt_d;
    logic signed [c_AW-1:0] acc_i_q,  acc_i_d;
    logic signed [c_AW-1:0] acc_q_q,  acc_q_d;
    logic signed [c_AW-1:0] dump_i_q, dump_i_d;
    logic signed [c_AW-1:0] dump_q_q, dump_q_d;
    logic                   v1_q,     v1_d;

    logic signed [c_AW-1:0] w_i_ext;
    logic signed [c_AW-1:0] w_q_ext;
    logic signed [c_AW-1:0] w_sum_i;
    logic signed [c_AW-1:0] w_sum_q;

    assign w_i_ext = {{ACC_LOG2{i_tdata[WIDTH-1]}}, i_tdata};
    assign w_q_ext = {{ACC_LOG2{q_tdata[WIDTH-1]}}, q_tdata};
    assign w_sum_i = acc_i_q + w_i_ext;
    assign w_sum_q = acc_q_q + w_q_ext;

    always_comb begin
        cnt_d    = cnt_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        dump_i_d = dump_i_q;
        dump_q_d = dump_q_q;
        v1_d     = 1'b0;
        if (iq_tvalid) begin
            cnt_d = cnt_q + ACC_LOG2'(1);
            if (cnt_q == c_CNT_LAST) begin
                // The dump includes the current sample; the accumulators
                // restart from zero so the next sample opens a fresh symbol.
                dump_i_d = w_sum_i;
                dump_q_d = w_sum_q;
                acc_i_d  = '0;
                acc_q_d  = '0;
                v1_d     = 1'b1;
            end else begin
                acc_i_d  = w_sum_i;
                acc_q_d  = w_sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            dump_i_q <= '0;
            dump_q_q <= '0;
            v1_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            dump_i_q <= dump_i_d;
            dump_q_q <= dump_q_d;
            v1_q     <= v1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: BPSK phase error err = sign(I) * mean(Q)
    // ------------------------------------------------------------------------
    logic signed [WIDTH-1:0] err_q, err_d;
    logic                    v2_q,  v2_d;

    logic signed [WIDTH-1:0] w_mean_q;
    logic signed [WIDTH-1:0] w_neg_mean;

    // Arithmetic shift by ACC_LOG2 followed by truncation to WIDTH bits is
    // exactly this slice of the dump register.
    assign w_mean_q   = dump_q_q[c_AW-1:ACC_LOG2];
    // Only the most-negative mean cannot be negated in WIDTH bits.
    assign w_neg_mean = (w_mean_q == c_MIN_W) ? c_MAX_W : -w_mean_q;

    // The fractional bits of the Q dump only feed the optional lock detector.
    logic w_unused_dump_q_lsbs;
    assign w_unused_dump_q_lsbs = ^dump_q_q[ACC_LOG2-1:0];

    always_comb begin
        err_d = err_q;
        v2_d  = v1_q;
        if (v1_q) begin
            // Zero in-phase dump is treated as positive.
            err_d = dump_i_q[c_AW-1] ? w_neg_mean : w_mean_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            v2_q  <= v2_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: saturating PI loop filter
    // ------------------------------------------------------------------------
    logic signed [WIDTH-1:0] integ_q, integ_d;
    logic signed [WIDTH-1:0] fb_data_q, fb_data_d;
    logic                    fb_valid_q, fb_valid_d;

    logic signed [WIDTH-1:0] w_ki_term;
    logic signed [WIDTH-1:0] w_kp_term;
    logic signed [WIDTH:0]   w_integ_sum;
    logic signed [WIDTH-1:0] w_integ_next;
    logic signed [WIDTH:0]   w_out_sum;
    logic signed [WIDTH-1:0] w_out;

    // Arithmetic shifts round toward minus infinity.
    assign w_ki_term    = err_q >>> KI_SHIFT;
    assign w_kp_term    = err_q >>> KP_SHIFT;
    assign w_integ_sum  = {integ_q[WIDTH-1], integ_q} + {w_ki_term[WIDTH-1], w_ki_term};
    assign w_integ_next = sat_w(w_integ_sum);
    // The proportional path uses the already-updated integrator value.
    assign w_out_sum    = {w_kp_term[WIDTH-1], w_kp_term} + {w_integ_next[WIDTH-1], w_integ_next};
    assign w_out        = sat_w(w_out_sum);

    always_comb begin
        integ_d    = integ_q;
        fb_data_d  = fb_data_q;
        fb_valid_d = v2_q;
        if (v2_q) begin
            integ_d   = w_integ_next;
            fb_data_d = w_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q    <= '0;
            fb_data_q  <= '0;
            fb_valid_q <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            fb_data_q  <= fb_data_d;
            fb_valid_q <= fb_valid_d;
        end
    end

    assign feedback_tdata  = fb_data_q;
    assign feedback_tvalid = fb_valid_q;

    // ------------------------------------------------------------------------
    // Optional lock detector
    // ------------------------------------------------------------------------
`ifdef COSTAS_LOCK_DETECT_EN
    logic           good_q,     good_d;
    logic [3:0]     lock_cnt_q, lock_cnt_d;
    logic           lock_q,     lock_d;

    logic [c_AW:0]   w_di_x;
    logic [c_AW:0]   w_dq_x;
    logic [c_AW:0]   w_abs_i;
    logic [c_AW:0]   w_abs_q;
    logic            w_good;

    // Magnitudes need one extra bit so the most-negative dump is representable.
    assign w_di_x  = {dump_i_q[c_AW-1], dump_i_q};
    assign w_dq_x  = {dump_q_q[c_AW-1], dump_q_q};
    assign w_abs_i = dump_i_q[c_AW-1] ? -w_di_x : w_di_x;
    assign w_abs_q = dump_q_q[c_AW-1] ? -w_dq_x : w_dq_x;
    // A symbol is good when |I| > 2|Q|; the doubling is a one-bit left shift.
    assign w_good  = {1'b0, w_abs_i} > {w_abs_q, 1'b0};

    always_comb begin
        good_d     = v1_q ? w_good : good_q;
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (v2_q) begin
            if (good_q) begin
                lock_cnt_d = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
            end else begin
                lock_cnt_d = 4'd0;
            end
            // Count >= 8 is exactly bit 3 of the 4-bit counter.
            lock_d = lock_cnt_d[3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q     <= 1'b0;
            lock_cnt_q <= 4'd0;
            lock_q     <= 1'b0;
        end else begin
            good_q     <= good_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_costas_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_costas_loop_filter
// Purpose  : Self-checking bench for costas_loop_filter. A behavioural model
//            works on whole symbols with integer arithmetic and predicts each
//            feedback pulse (value, arrival cycle, lock flag).
// Options  : COSTAS_LOCK_DETECT_EN - also expects the lock indicator to work.
// Revision : 1.0 - initial release
// ============================================================================
module tb_costas_loop_filter;

    localparam int c_LEN = 16;
    localparam int c_KP  = 4;
    localparam int c_KI  = 64;
`ifdef COSTAS_LOCK_DETECT_EN
    localparam bit c_LOCK_EN = 1'b1;
`else
    localparam bit c_LOCK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] i_tdata;
    logic signed [15:0] q_tdata;
    logic               iq_tvalid;
    logic signed [15:0] feedback_tdata;
    logic               feedback_tvalid;
    logic               lock;

    always #5 clk = ~clk;

    costas_loop_filter #(
        .WIDTH   (16),
        .ACC_LOG2(4),
        .KP_SHIFT(2),
        .KI_SHIFT(6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_tdata        (i_tdata),
        .q_tdata        (q_tdata),
        .iq_tvalid      (iq_tvalid),
        .feedback_tdata (feedback_tdata),
        .feedback_tvalid(feedback_tvalid),
        .lock           (lock)
    );

    typedef struct {
        int   data;
        int   cyc;
        logic lk;
    } pulse_t;

    pulse_t obs_q[$];
    pulse_t exp_q[$];
    int     cyc          = 0;
    int     pulse_count  = 0;
    int     n_compared   = 0;
    int     n_mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pulse_t p;
        if (feedback_tvalid === 1'b1) begin
            p.data = int'(feedback_tdata);
            p.cyc  = cyc;
            p.lk   = lock;
            obs_q.push_back(p);
            pulse_count++;
        end
    end

    // ---------------- behavioural model ----------------
    int     m_cnt;
    longint m_si, m_sq;
    int     m_integ;
    int     m_lcnt;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_si = 0; m_sq = 0; m_integ = 0; m_lcnt = 0;
    endtask

    task automatic drive_sample(input int iv, input int qv);
        pulse_t e;
        int     mean, err;
        @(negedge clk);
        i_tdata   = iv[15:0];
        q_tdata   = qv[15:0];
        iq_tvalid = 1'b1;
        m_si += iv;
        m_sq += qv;
        m_cnt++;
        if (m_cnt == c_LEN) begin
            mean    = int'(fdiv(m_sq, c_LEN));
            err     = (m_si >= 0) ? mean : sat16(-longint'(mean));
            m_integ = sat16(longint'(m_integ) + fdiv(err, c_KI));
            if (labs(m_si) > 2 * labs(m_sq)) m_lcnt = (m_lcnt < 15) ? m_lcnt + 1 : 15;
            else                             m_lcnt = 0;
            e.data = sat16(fdiv(err, c_KP) + m_integ);
            e.cyc  = cyc + 3;
            e.lk   = c_LOCK_EN && (m_lcnt >= 8);
            exp_q.push_back(e);
            m_cnt = 0; m_si = 0; m_sq = 0;
        end
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iq_tvalid = 1'b0;
            i_tdata   = 16'($urandom);
            q_tdata   = 16'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        iq_tvalid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        obs_q.delete();
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(3);
        n_compared++;
        if (feedback_tdata !== 16'sd0) begin
            n_mismatched++;
            $display("FAIL reset_tdata: got %0d, expected 0", feedback_tdata);
        end
        n_compared++;
        if (feedback_tvalid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_tvalid: got %b, expected 0", feedback_tvalid);
        end
        n_compared++;
        if (lock !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_lock: got %b, expected 0", lock);
        end
    endtask

    task automatic test_zero_q();
        pulse_t e, o;
        do_reset(2);
        for (int k = 0; k < c_LEN; k++) drive_sample(1000, 0);
        drive_idle(6);
        n_compared++;
        if (obs_q.size() != 1 || obs_q[0].data !== 0) begin
            n_mismatched++;
            $display("FAIL zero_q_literal: got %0d pulses, expected 1 pulse of 0", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL zero_q_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL zero_q_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (feedback_tvalid !== 1'b0 || feedback_tdata !== 16'sd0) begin
            n_mismatched++;
            $display("FAIL zero_q_hold: got valid=%b data=%0d, expected valid=0 data=0", feedback_tvalid, feedback_tdata);
        end
    endtask

    task automatic test_pos_err();
        pulse_t e, o;
        int g0, g1;
        do_reset(2);
        for (int k = 0; k < 2 * c_LEN; k++) drive_sample(1000, 400);
        drive_idle(6);
        g0 = (obs_q.size() > 0) ? obs_q[0].data : -99999;
        g1 = (obs_q.size() > 1) ? obs_q[1].data : -99999;
        n_compared++;
        if (g0 !== 106 || g1 !== 112) begin
            n_mismatched++;
            $display("FAIL pos_err_literal: got %0d,%0d expected 106,112", g0, g1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL pos_err_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL pos_err_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL pos_err_extra: got %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_neg_err();
        pulse_t e, o;
        int g0;
        do_reset(2);
        for (int k = 0; k < c_LEN; k++) drive_sample(-1000, 400);
        drive_idle(6);
        g0 = (obs_q.size() > 0) ? obs_q[0].data : -99999;
        n_compared++;
        if (g0 !== -107) begin
            n_mismatched++;
            $display("FAIL neg_err_literal: got %0d expected -107", g0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL neg_err_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL neg_err_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
    endtask

    task automatic test_gaps();
        pulse_t e, o;
        int pc0;
        do_reset(2);
        pc0 = pulse_count;
        for (int k = 0; k < c_LEN - 1; k++) begin
            drive_sample(int'($urandom_range(2000, 0)) - 1000, int'($urandom_range(2000, 0)) - 1000);
            drive_idle(1);
        end
        drive_idle(4);
        n_compared++;
        if (pulse_count != pc0) begin
            n_mismatched++;
            $display("FAIL gaps_early: got %0d pulses before 16th sample, expected 0", pulse_count - pc0);
        end
        drive_sample(300, -200);
        drive_idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL gaps_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL gaps_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL gaps_extra: got %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_random();
        pulse_t e, o;
        do_reset(2);
        for (int s = 0; s < 8 * c_LEN; s++) begin
            drive_sample(rnd16(), rnd16());
            if ($urandom_range(2, 0) == 0) drive_idle(int'($urandom_range(4, 1)));
        end
        drive_idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL random_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL random_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL random_extra: got %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        pulse_t e, o;
        int bi, bq;
        for (int s = 0; s < 6; s++) begin
            bi = int'($urandom_range(4000, 0)) - 2000;
            bq = int'($urandom_range(4000, 0)) - 2000;
            for (int k = 0; k < c_LEN; k++)
                drive_sample(bi + int'($urandom_range(200, 0)) - 100, bq + int'($urandom_range(200, 0)) - 100);
        end
        drive_idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL b2b_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL b2b_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL b2b_extra: got %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_saturation();
        pulse_t e, o;
        int n_neg, last;
        do_reset(2);
        for (int s = 0; s < 2000 * c_LEN; s++) drive_sample(-1, -32768);
        drive_idle(6);
        n_neg = 0;
        foreach (obs_q[k]) if (obs_q[k].data < 0) n_neg++;
        last = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].data : -99999;
        n_compared++;
        if (n_neg != 0 || last !== 32767 || obs_q.size() != 2000) begin
            n_mismatched++;
            $display("FAIL sat_literal: got %0d pulses, %0d negative, last=%0d; expected 2000, 0, 32767", obs_q.size(), n_neg, last);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL sat_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL sat_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        pulse_t e, o;
        do_reset(2);
        for (int k = 0; k < 7; k++) drive_sample(5000, 5000);
        do_reset(1);
        for (int k = 0; k < c_LEN; k++) drive_sample(1000, 400);
        drive_idle(6);
        n_compared++;
        if (obs_q.size() != 1) begin
            n_mismatched++;
            $display("FAIL mid_reset_count: got %0d pulses, expected 1", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL mid_reset_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL mid_reset_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_lock();
        pulse_t e, o;
        logic want, got;
        do_reset(2);
        for (int k = 0; k < 8 * c_LEN; k++) drive_sample(1000, 0);
        for (int k = 0; k < c_LEN; k++) drive_sample(1000, 1000);
        drive_idle(6);
        for (int k = 0; k < 9; k++) begin
            want = c_LOCK_EN && (k == 7);
            got  = (obs_q.size() > k) ? obs_q[k].lk : 1'bx;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL lock_seq[%0d]: got %b, expected %b", k, got, want);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_compared++;
            if (obs_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL lock_pulse: got none, expected data=%0d cyc=%0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc !== e.cyc || o.lk !== e.lk) begin
                    n_mismatched++;
                    $display("FAIL lock_pulse: got data=%0d cyc=%0d lock=%b, expected data=%0d cyc=%0d lock=%b", o.data, o.cyc, o.lk, e.data, e.cyc, e.lk);
                end
            end
        end
        n_compared++;
        if (lock !== 1'b0) begin
            n_mismatched++;
            $display("FAIL lock_after_bad: got %b, expected 0", lock);
        end
    endtask

    initial begin
        rst       = 1'b1;
        iq_tvalid = 1'b0;
        i_tdata   = '0;
        q_tdata   = '0;
        model_reset();
        test_reset();
        test_zero_q();
        test_pos_err();
        test_neg_err();
        test_gaps();
        test_random();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/costas_loop_filter.md
Name: costas_loop_filter

Overview:
- Produces the phase-increment correction stream consumed by the NCO phase generator. It is the feedback end of the Costas loop.
- Takes the baseband I/Q mixer products and integrates-and-dumps them over one symbol. It then forms the BPSK Costas phase error sign(I)*Q and runs it through a saturating proportional-integral (PI) loop filter.
- It emits one signed correction word per symbol on a tdata/tvalid pair. There is no backpressure.

Parameters:
- WIDTH, 16: bit width of I/Q samples and of feedback_tdata (two's complement).
- ACC_LOG2, 4: log2 of the samples per integrate-and-dump. ACC_LEN = 2^ACC_LOG2 = 16.
- KP_SHIFT, 2: proportional gain = 2^-KP_SHIFT (arithmetic right shift).
- KI_SHIFT, 6: integral gain = 2^-KI_SHIFT (arithmetic right shift).

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous active-high reset.
- i_tdata, input, WIDTH: signed in-phase mixer output.
- q_tdata, input, WIDTH: signed quadrature mixer output.
- iq_tvalid, input, 1: I/Q sample valid; a sample is accepted on every cycle this is high.
- feedback_tdata, output, WIDTH: signed phase-increment correction.
- feedback_tvalid, output, 1: one-cycle pulse per symbol.
- lock, output, 1: lock indicator (see Optional Feature); tied 0 when the feature is disabled.

Behaviour:
- Reset:
  - Clears the sample counter, acc_i, acc_q, the dump registers, the error register and the integrator.
  - Outputs reset values: feedback_tdata=0, feedback_tvalid=0, lock=0.
  - Reset mid-symbol discards the partial accumulation; the first dump after reset needs a full ACC_LEN valid samples.
- Accumulators:
  - acc_i and acc_q are WIDTH+ACC_LOG2 bits signed; the sum cannot overflow.
  - On each accepted sample: acc += sign-extended sample. The counter (ACC_LOG2 bits) increments and wraps.
  - Invalid cycles hold all state; gaps in iq_tvalid are allowed anywhere inside a symbol.
- Dump, on the accepted sample where counter == ACC_LEN-1:
  - Latch dump_i = acc_i + sample and dump_q = acc_q + sample.
  - Load the accumulators with 0, not the sample; the next sample starts a new sum.
  - Set the stage-1 valid flag.
- Stage 2, phase error:
  - mean_q = dump_q >>> ACC_LOG2, truncated to WIDTH bits.
  - err = mean_q if dump_i >= 0 (zero counts as positive), else -mean_q.
  - Negating the most-negative value saturates to +(2^(WIDTH-1)-1).
- Stage 3, PI filter:
  - integ_next = sat_WIDTH(integ + (err >>> KI_SHIFT)).
  - out = sat_WIDTH((err >>> KP_SHIFT) + integ_next), computed in WIDTH+1 bits.
  - Register integ <= integ_next, feedback_tdata <= out, feedback_tvalid <= 1.
- Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency:
  - Last sample of a symbol accepted at cycle N gives feedback_tvalid high at cycle N+3 for exactly one cycle.
  - feedback_tdata holds its value until the next pulse.
- Back-to-back: ACC_LEN >= 2 guarantees the pipeline never overlaps. No FIFO and no ready signal.
- iq_tvalid low during stages 2-3 does not stall the pipeline.

Optional Feature:
- Macro: COSTAS_LOCK_DETECT_EN.
- Enabled:
  - Per dump, a symbol is "good" if |dump_i| > 2*|dump_q|.
  - A 4-bit saturating counter increments on good symbols and clears on bad ones.
  - lock = 1 once the counter reaches 8; lock = 0 on the first bad symbol.
  - lock updates in the same cycle as feedback_tvalid.
- Disabled: no detector logic is compiled; lock is constant 0.

Test Plan:
1. Reset then 16 valid samples with I=1000, Q=0 -> feedback_tvalid pulses 3 cycles after the 16th sample; feedback_tdata=0; integ=0.
2. Constant I=1000, Q=400, defaults -> err=400, integ=6, out=100+6=106. Second symbol: integ=12, out=112.
3. I=-1000, Q=400 -> err=-400, first out = -100 + (-7) = -107 (arithmetic shift rounds toward -inf).
4. iq_tvalid toggling 1/0 each cycle -> pulse only after the 16th accepted sample; no pulse is produced by the invalid cycles.
5. Q=-32768, I=-1, ACC_LOG2=4 held for 2000 symbols -> err saturates to 32767; feedback_tdata settles at 32767 and never wraps negative.
6. Reset asserted after 7 samples, then 16 samples -> exactly one pulse, 3 cycles after the 16th post-reset sample. With COSTAS_LOCK_DETECT_EN: 8 good symbols -> lock=1 on the 8th pulse; one symbol with Q=I -> lock=0.
